// File: rtl/sev_seg_mux_n.sv
// N-digit multiplexed seven-segment driver with built-in scan prescaler,
// frame-latched inputs, leading-zero suppression, blanking and selectable polarity.
module sev_seg_mux_n #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV_BITS   = 15,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk_main,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      lz_suppress,
  output logic [7:0]                sev_seg_leds,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_sync
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SegOff  = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SelOff  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [DIV_BITS-1:0]     cnt_q;
  logic                    tick;
  logic                    tick_q;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] sh_digits_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q;
  logic                    sh_lz_q;

  logic [7:0]              leds_q, leds_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign tick = &cnt_q;
  assign wrap = tick && (idx_q == LastIdx);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      idx_q  <= LastIdx;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= tick;
      idx_q  <= idx_d;
    end
  end

  // Inputs are sampled only at frame start so a frame never mixes old and new values.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lz_q     <= 1'b0;
    end else if (wrap) begin
      sh_digits_q <= digits;
      sh_dp_q     <= dp;
      sh_blank_q  <= blank_mask;
      sh_lz_q     <= lz_suppress;
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  suppress;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] sel_oh;
  logic [7:0]            seg_raw;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    suppress  = 1'b0;
    zero_run  = 1'b1;
    sel_oh    = '0;
    // Walk from the most significant digit down so zero_run covers this digit and all above.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_digits_q[4*i +: 4] == 4'h0);
      if (idx_q == IdxW'(i)) begin
        cur_nib   = sh_digits_q[4*i +: 4];
        cur_dp    = sh_dp_q[i];
        cur_blank = sh_blank_q[i];
        sel_oh[i] = 1'b1;
        suppress  = sh_lz_q && (i != 0) && zero_run;
      end
    end
    seg_raw = {cur_dp, suppress ? 7'h00 : hex_to_seg(cur_nib)};
    if (cur_blank) begin
      seg_raw = '0;
      sel_oh  = '0;
    end
    leds_d = seg_raw ^ SegOff;
    sel_d  = sel_oh ^ SelOff;
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      leds_q <= SegOff;
      sel_q  <= SelOff;
      fs_q   <= 1'b0;
    end else begin
      fs_q <= tick_q && (idx_q == '0);
      if (tick_q) begin
        leds_q <= leds_d;
        sel_q  <= sel_d;
      end
    end
  end

  assign sev_seg_leds = leds_q;
  assign digit_sel    = sel_q;
  assign frame_sync   = fs_q;

endmodule

// File: tb/tb_sev_seg_mux_n.sv
// Directed bench for sev_seg_mux_n: 4 digits, 16-clock scan step, active-low outputs.
module tb_sev_seg_mux_n;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h12AF;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blank_mask = 4'b0000;
  logic        lz_suppress = 1'b0;
  logic [7:0]  sev_seg_leds;
  logic [3:0]  digit_sel;
  logic        frame_sync;

  int checks = 0;
  int errors = 0;

  sev_seg_mux_n #(
    .NUM_DIGITS(4),
    .DIV_BITS  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .digits      (digits),
    .dp          (dp),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .sev_seg_leds(sev_seg_leds),
    .digit_sel   (digit_sel),
    .frame_sync  (frame_sync)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [7:0] leds);
    chk({tag, "_sel"}, {28'h0, digit_sel}, {28'h0, sel});
    chk({tag, "_leds"}, {24'h0, sev_seg_leds}, {24'h0, leds});
  endtask

  // Advance n rising edges, then park on the following falling edge for sampling.
  task automatic adv(input int n);
    repeat (n) @(posedge clk_main);
    @(negedge clk_main);
  endtask

  initial begin
    // Test 1: reset state and first frame start
    repeat (3) @(negedge clk_main);
    chk_out("rst", 4'b1111, 8'hFF);
    chk("rst_fs", {31'h0, frame_sync}, 32'h0);
    reset = 1'b0;
    adv(16);
    chk_out("pre_first", 4'b1111, 8'hFF);
    chk("pre_first_fs", {31'h0, frame_sync}, 32'h0);
    adv(1);
    chk_out("d0_f1", 4'b1110, 8'h8E);
    chk("d0_f1_fs", {31'h0, frame_sync}, 32'h1);
    adv(1);
    chk("fs_one_cycle", {31'h0, frame_sync}, 32'h0);
    chk_out("d0_hold", 4'b1110, 8'h8E);

    // Test 2: scan through 12AF and wrap
    adv(15);
    chk_out("d1_f1", 4'b1101, 8'h88);
    chk("d1_fs", {31'h0, frame_sync}, 32'h0);
    adv(16);
    chk_out("d2_f1", 4'b1011, 8'hA4);
    adv(16);
    chk_out("d3_f1", 4'b0111, 8'hF9);
    adv(16);
    chk_out("d0_f2", 4'b1110, 8'h8E);
    chk("d0_f2_fs", {31'h0, frame_sync}, 32'h1);

    // Test 3: mid-frame change must not tear
    adv(16);
    chk_out("d1_f2", 4'b1101, 8'h88);
    digits = 16'h5555;
    adv(16);
    chk_out("tear_d2", 4'b1011, 8'hA4);
    adv(16);
    chk_out("tear_d3", 4'b0111, 8'hF9);
    adv(16);
    chk_out("new_d0", 4'b1110, 8'h92);
    adv(16);
    chk_out("new_d1", 4'b1101, 8'h92);
    adv(16);
    chk_out("new_d2", 4'b1011, 8'h92);
    adv(16);
    chk_out("new_d3", 4'b0111, 8'h92);

    // Test 4: leading-zero suppression
    lz_suppress = 1'b1;
    digits = 16'h0030;
    adv(16);
    chk_out("lz30_d0", 4'b1110, 8'hC0);
    adv(16);
    chk_out("lz30_d1", 4'b1101, 8'hB0);
    adv(16);
    chk_out("lz30_d2", 4'b1011, 8'hFF);
    adv(16);
    chk_out("lz30_d3", 4'b0111, 8'hFF);
    digits = 16'h0000;
    adv(16);
    chk_out("lz00_d0", 4'b1110, 8'hC0);
    adv(16);
    chk_out("lz00_d1", 4'b1101, 8'hFF);
    adv(16);
    chk_out("lz00_d2", 4'b1011, 8'hFF);
    adv(16);
    chk_out("lz00_d3", 4'b0111, 8'hFF);

    // Test 5: blanking and decimal point
    lz_suppress = 1'b0;
    blank_mask = 4'b0100;
    dp = 4'b0001;
    adv(16);
    chk_out("bl_d0", 4'b1110, 8'h40);
    adv(16);
    chk_out("bl_d1", 4'b1101, 8'hC0);
    adv(16);
    chk_out("bl_d2", 4'b1111, 8'hFF);
    adv(16);
    chk_out("bl_d3", 4'b0111, 8'hC0);

    // Test 6: asynchronous reset mid-frame, between edges
    adv(5);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 4'b1111, 8'hFF);
    chk("async_rst_fs", {31'h0, frame_sync}, 32'h0);
    @(negedge clk_main);
    reset = 1'b0;
    adv(16);
    chk_out("rel_pre", 4'b1111, 8'hFF);
    adv(1);
    chk_out("rel_d0", 4'b1110, 8'h40);
    chk("rel_d0_fs", {31'h0, frame_sync}, 32'h1);
    adv(16);
    chk_out("rel_d1", 4'b1101, 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sev_seg_mux_n.md
Name: sev_seg_mux_n

Overview:
Parametrised N-digit multiplexed seven-segment display driver with a built-in scan prescaler.
- Runs directly off the board clock; no external divided clock is needed.
- Decodes per-digit hex nibbles and drives one digit at a time.
- Adds per-digit decimal points, per-digit blanking, leading-zero suppression, selectable polarity, and tear-free frame-latched inputs.
- Replaces fixed two-digit drivers in the divider and follow-on display projects.

Parameters:
NUM_DIGITS, 8, number of digit positions scanned; legal range 1..8.
DIV_BITS, 15, prescaler width; one scan step every 2^DIV_BITS clk_main cycles; minimum 1.
ACTIVE_LOW, 1, 1 means segments and digit selects are active-low (common-anode boards); 0 means active-high.

Ports:
clk_main  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
digits  input  4*NUM_DIGITS  hex value per digit; digit i is bits [4i+3:4i]; digit 0 is rightmost/least significant.
dp  input  NUM_DIGITS  decimal point request per digit.
blank_mask  input  NUM_DIGITS  1 means digit fully off (select inactive, segments off).
lz_suppress  input  1  1 enables leading-zero suppression.
sev_seg_leds  output  8  bit0=a … bit6=g, bit7=dp; registered.
digit_sel  output  NUM_DIGITS  one-hot (in active polarity) digit select; registered.
frame_sync  output  1  one-cycle pulse coincident with the output update that selects digit 0.

Behaviour:
- Prescaler: DIV_BITS free-running up-counter, reset 0, wraps.
  - tick = counter all-ones (one-cycle pulse every 2^DIV_BITS clocks).
- Scan index: reset value NUM_DIGITS-1.
  - On tick: index = (index==NUM_DIGITS-1) ? 0 : index+1.
  - The first tick after reset therefore selects digit 0.
- Shadow registers: hold digits, dp, blank_mask and lz_suppress; reset value 0.
  - Loaded only on the tick where the index wraps to 0.
  - Input changes mid-frame take effect at the next frame start (no tearing).
- Output update: occurs on the clock after tick (tick delayed one cycle). Outputs are decoded from the shadow registers for the current index.
  - Latency is tick + 1 clock.
  - Outputs hold between updates.
- Hex decode, active-high form (a..g, bit6..bit0 shown as hex with dp=0):
  0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - dp sets bit7.
  - ACTIVE_LOW=1 inverts all 8 segment bits and the select.
- Leading-zero suppression: digit i (i≥1) is suppressed when lz_suppress is set, its nibble is 0, and every higher digit's nibble is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its select active and has a–g off; its dp is still shown if requested.
- Blanking: a blank_mask bit overrides everything. For that slot, digit_sel is all inactive and segments/dp are off. Scan timing is unchanged and the slot time is kept.
- frame_sync: asserted for exactly the one clock in which outputs switch to digit 0.
- Reset (async, any time, including mid-frame):
  - Outputs go immediately to all-off (sev_seg_leds=FF and digit_sel all ones for ACTIVE_LOW=1; all zeros for ACTIVE_LOW=0).
  - frame_sync=0; prescaler, index and shadows take their reset values.
  - Release restarts at digit 0 after 2^DIV_BITS clocks.
- NUM_DIGITS=1: the index stays 0, and the shadow reloads every tick.

Test Plan:
1. NUM_DIGITS=4, DIV_BITS=4, ACTIVE_LOW=1; hold reset -> sev_seg_leds=FF, digit_sel=1111, frame_sync=0. Release -> at cycle 17, digit_sel=1110 and frame_sync pulses for 1 cycle.
2. digits=16'h12AF, dp=0 -> successive updates every 16 clocks show (digit_sel, leds) = (1110,8E), (1101,88), (1011,A4), (0111,F9), then wrap to (1110,8E).
3. Start with digits=16'h12AF; change to 16'h5555 while digit 1 is displayed -> digits 2 and 3 still show A4 and F9; the next frame shows 92 on all four.
4. lz_suppress=1, digits=16'h0030 -> digits 3 and 2 show FF with selects active, digit 1 shows B0, digit 0 shows C0. With digits=16'h0000, only digit 0 shows C0.
5. blank_mask=0100, dp=0001, digits=16'h0000 -> digit 2 slot gives digit_sel=1111 and leds=FF; digit 0 gives leds=40.
6. Assert reset asynchronously mid-frame, between clock edges -> outputs go all-off before the next edge. After release, the sequence restarts at digit 0 after 16 clocks.
